// File: rtl/shift_reg_iterativo_pkg.sv
// Shared definitions for the iterative shifter: operation encodings (they
// match the control unit's shift-function field), FSM state encoding and
// the constant shift amount used by the amount-select path.
// Optional feature macro: SHIFTER_ROTATE_EN (enables ROR/ROL execution).
package shift_reg_iterativo_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int SHW_DEF   = 5;

  // Constant amount offered by the amount-select path (lui-style moves).
  localparam logic [4:0] SHIFT_SIXTEEN = 5'd16;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_LOAD = 3'b001,
    OP_SLL  = 3'b010,
    OP_SRL  = 3'b011,
    OP_SRA  = 3'b100,
    OP_ROR  = 3'b101,
    OP_ROL  = 3'b110,
    OP_RSVD = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  // True when the operation consumes the shift amount. Operations that do
  // not shift start with a zero count, so they finish in the minimum time.
  function automatic logic op_uses_count(input op_e op);
    logic uses;
    uses = 1'b0;
    case (op)
      OP_SLL, OP_SRL, OP_SRA: uses = 1'b1;
`ifdef SHIFTER_ROTATE_EN
      OP_ROR, OP_ROL:         uses = 1'b1;
`else
      OP_ROR, OP_ROL:         uses = 1'b0;
`endif
      default:                uses = 1'b0;
    endcase
    return uses;
  endfunction

endpackage

// File: rtl/shift_reg_iterativo_shift_step.sv
// Combinational one-bit shifter: computes the value after a single step of
// the requested operation. Non-shifting operations pass the value through.
// Optional feature macro: SHIFTER_ROTATE_EN (rotate steps are only built
// when it is defined; otherwise ROR/ROL pass through like LOAD).
module shift_step
  import shift_reg_iterativo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  op_e              op_i,
  input  logic [WIDTH-1:0] value_i,
  output logic [WIDTH-1:0] value_o
);

  // Select the one-bit step for the current operation.
  always_comb begin
    value_o = value_i;
    case (op_i)
      OP_SLL:  value_o = {value_i[WIDTH-2:0], 1'b0};
      OP_SRL:  value_o = {1'b0, value_i[WIDTH-1:1]};
      OP_SRA:  value_o = {value_i[WIDTH-1], value_i[WIDTH-1:1]};
`ifdef SHIFTER_ROTATE_EN
      OP_ROR:  value_o = {value_i[0], value_i[WIDTH-1:1]};
      OP_ROL:  value_o = {value_i[WIDTH-2:0], value_i[WIDTH-1]};
`endif
      default: value_o = value_i;
    endcase
  end

endmodule

// File: rtl/shift_reg_iterativo.sv
// Iterative shift register: accepts an operand, an operation and a shift
// amount, applies one bit of shift per clock and pulses done when the
// result is ready on data_out. Used by the multicycle control unit, which
// waits on done before writing back.
// Optional feature macro: SHIFTER_ROTATE_EN (ROR/ROL execute when defined;
// otherwise they are accepted and behave like LOAD).
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | waiting for start with a non-NOP op; outputs hold last result
//   S_SHIFT | one step per cycle while count != 0, then move to S_DONE
//   S_DONE  | done and busy both high for this single cycle
module shift_reg_iterativo
  import shift_reg_iterativo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SHW   = SHW_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [SHW-1:0]   n,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  op_e              op_in;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] step_value;
  logic [SHW-1:0]   count_q, count_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  assign op_in = op_e'(op);

  shift_step #(
    .WIDTH (WIDTH)
  ) u_shift_step (
    .op_i    (op_q),
    .value_i (data_q),
    .value_o (step_value)
  );

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_NOP;
      data_q  <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and datapath update; start is only looked at in S_IDLE.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    count_d = count_q;
    busy_d  = busy_q;
    done_d  = done_q;
    case (state_q)
      S_IDLE: begin
        if (start && (op_in != OP_NOP)) begin
          data_d  = data_in;
          op_d    = op_in;
          count_d = op_uses_count(op_in) ? n : '0;
          busy_d  = 1'b1;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (count_q != '0) begin
          data_d  = step_value;
          count_d = count_q - 1'b1;
        end else begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        count_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign data_out = data_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_shift_reg_iterativo.sv
// Directed bench for shift_reg_iterativo: expected results and latencies are
// computed by a reference model, queued when an operation is started and
// compared when done is observed.
module tb_shift_reg_iterativo;
  import shift_reg_iterativo_pkg::*;

  localparam int W = 32;
  localparam int S = 5;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   op = 3'b000;
  logic [S-1:0] n = '0;
  logic [W-1:0] data_in = '0;
  logic [W-1:0] data_out;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] data;
    int           lat;
    string        tag;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] last_result = '0;

  shift_reg_iterativo #(.WIDTH(W), .SHW(S)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .n        (n),
    .data_in  (data_in),
    .data_out (data_out),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] model_res(input logic [2:0] o, input logic [4:0] a,
                                             input logic [W-1:0] d);
    logic [2*W-1:0] dd;
    logic signed [W-1:0] sd;
    dd = {d, d};
    sd = d;
    case (o)
      3'b010: return d << a;
      3'b011: return d >> a;
      3'b100: return sd >>> a;
`ifdef SHIFTER_ROTATE_EN
      3'b101: begin dd = dd >> a; return dd[W-1:0]; end
      3'b110: begin dd = dd << a; return dd[2*W-1:W]; end
`endif
      default: return d;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] o, input logic [4:0] a);
    case (o)
      3'b010, 3'b011, 3'b100: return int'(a) + 2;
`ifdef SHIFTER_ROTATE_EN
      3'b101, 3'b110: return int'(a) + 2;
`endif
      default: return 2;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; drives start there, follows the operation until
  // done, and returns at the negedge of the following IDLE cycle.
  task automatic run_op(input logic [2:0] o, input logic [4:0] a, input logic [W-1:0] d,
                        input string tag, input int inject_at);
    exp_t e;
    int   cyc;
    bit   seen;
    sb.push_back('{model_res(o, a, d), model_lat(o, a), tag});
    start = 1'b1; op = o; n = a; data_in = d;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 64) begin
      @(negedge clk);
      cyc++;
      start   = (cyc == inject_at);
      op      = 3'b011;
      n       = S'($urandom);
      data_in = $urandom;
      chk({tag, " busy"}, W'(busy), W'(1'b1));
      if (done === 1'b1) seen = 1'b1;
    end
    start = 1'b0;
    e = sb.pop_front();
    chk({e.tag, " done_seen"}, W'(seen), W'(1'b1));
    chk({e.tag, " latency"}, W'(cyc), W'(e.lat));
    chk({e.tag, " data"}, data_out, e.data);
    @(negedge clk);
    chk({e.tag, " done_cleared"}, W'(done), W'(1'b0));
    chk({e.tag, " busy_cleared"}, W'(busy), W'(1'b0));
    chk({e.tag, " data_hold"}, data_out, e.data);
    last_result = e.data;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset data_out", data_out, '0);
    chk("reset busy", W'(busy), '0);
    chk("reset done", W'(done), '0);
    reset = 1'b0;

    run_op(3'b010, 5'd4, 32'h0000_0001, "sll_n4", 0);
    run_op(3'b100, 5'd31, 32'h8000_0000, "sra_n31", 0);
    run_op(3'b011, SHIFT_SIXTEEN, 32'h8000_0000, "srl_n16", 0);
    run_op(3'b001, 5'd0, 32'hDEAD_BEEF, "load_n0", 0);
    run_op(3'b001, 5'd7, 32'h1234_5678, "load_n7", 0);
    run_op(3'b111, 5'd5, 32'hA5A5_0F0F, "rsvd_n5", 0);

    // NOP start: nothing should change.
    start = 1'b1; op = 3'b000; n = 5'd5; data_in = $urandom;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      start = 1'b0;
      chk("nop busy", W'(busy), '0);
      chk("nop done", W'(done), '0);
      chk("nop data_hold", data_out, last_result);
    end

    run_op(3'b101, 5'd1, 32'h0000_0001, "ror_n1", 0);
    run_op(3'b110, 5'd4, 32'h8000_0001, "rol_n4", 0);
    run_op(3'b100, 5'd3, 32'h4000_0000, "sra_pos_n3", 0);
    run_op(3'b011, 5'd0, 32'hCAFE_F00D, "srl_n0", 0);
    run_op(3'b010, 5'd20, 32'h0000_0003, "sll_n20_midstart", 5);

    // Reset in the middle of an operation.
    start = 1'b1; op = 3'b010; n = 5'd10; data_in = 32'h0000_0001;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    chk("abort data_out", data_out, '0);
    chk("abort busy", W'(busy), '0);
    chk("abort done", W'(done), '0);
    reset = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      chk("abort no_done", W'(done), '0);
      chk("abort no_busy", W'(busy), '0);
    end
    last_result = '0;

    run_op(3'b011, 5'd7, 32'hF000_0000, "fresh_srl_n7", 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
